// File: rtl/bitty_ctrl_pkg.sv
// Bitty control unit package: state encodings, instruction format codes and
// the format classification shared by the control FSM.
package bitty_ctrl_pkg;

    // FSM state encoding (binary, legacy-compatible constants)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_WB   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Instruction format field values (ir[1:0])
    localparam logic [1:0] FMT_REG  = 2'b00;
    localparam logic [1:0] FMT_IMM  = 2'b01;
    localparam logic [1:0] FMT_TEST = 2'b10;
    localparam logic [1:0] FMT_ILL  = 2'b11;

    // What a format means for sequencing: write Rx back, use the immediate, flag illegal
    typedef struct packed {
        logic wb;
        logic imm;
        logic ill;
    } fmt_class_t;

    // Width of the immediate field sitting between Rx and the ALU opcode
    function automatic int imm_width(input int instr_w, input int reg_w, input int alu_w);
        return instr_w - reg_w - alu_w - 2;
    endfunction

    // Classify a format; imm_en says whether reg-imm is built in
    function automatic fmt_class_t classify_fmt(input logic [1:0] fmt, input logic imm_en);
        fmt_class_t c;
        c.imm = (fmt == FMT_IMM) && imm_en;
        c.wb  = (fmt == FMT_REG) || c.imm;
        c.ill = (fmt == FMT_ILL) || ((fmt == FMT_IMM) && !imm_en);
        return c;
    endfunction

endpackage

// File: rtl/bitty_ctrl_if.sv
// Bitty control bus: run/instruction handshake in, datapath controls out.
// master = instruction source / datapath side, slave = control FSM.
interface bitty_ctrl_if
    import bitty_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3,
    parameter int ALU_SEL_W  = 3
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int IMM_W    = imm_width(INSTR_W, REG_ADDR_W, ALU_SEL_W);

    logic                  run;
    logic [INSTR_W-1:0]    instruction;
    logic [ALU_SEL_W-1:0]  alu_sel;
    logic [REG_ADDR_W-1:0] mux_sel;
    logic                  imm_sel;
    logic [IMM_W-1:0]      imm_value;
    logic [NUM_REGS-1:0]   reg_en;
    logic                  en_i;
    logic                  en_s;
    logic                  en_c;
    logic                  busy;
    logic                  done;
    logic                  illegal;

    modport master (
        output run, instruction,
        input  alu_sel, mux_sel, imm_sel, imm_value, reg_en,
               en_i, en_s, en_c, busy, done, illegal
    );

    modport slave (
        input  run, instruction,
        output alu_sel, mux_sel, imm_sel, imm_value, reg_en,
               en_i, en_s, en_c, busy, done, illegal
    );

endinterface

// File: rtl/bitty_ctrl_fsm_onehot_dec.sv
// Register-enable decoder: index plus enable to a one-hot write-enable vector.
module bitty_onehot_dec #(
    parameter int W = 3
) (
    input  logic [W-1:0]        i_idx,
    input  logic                i_en,
    output logic [(1<<W)-1:0]   o_onehot
);

    // Exactly one bit set when enabled, none otherwise
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bitty_ctrl_fsm.sv
// Bitty multi-cycle control unit: IDLE -> LOAD -> EXEC -> WB -> DONE.
// Latches one instruction per run handshake and drives the datapath enables.
// Optional feature macro: BITTY_IMM_EN (format 01 executes as reg-imm;
// when undefined, format 01 is flagged illegal and imm_sel stays 0).
module bitty_ctrl_fsm
    import bitty_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3,
    parameter int ALU_SEL_W  = 3
) (
    input  logic        clk,
    input  logic        rst,
    bitty_ctrl_if.slave bus
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int IMM_W    = imm_width(INSTR_W, REG_ADDR_W, ALU_SEL_W);

`ifdef BITTY_IMM_EN
    localparam logic IMM_EN = 1'b1;
`else
    localparam logic IMM_EN = 1'b0;
`endif

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [INSTR_W-1:0]    r_ir;

    logic [REG_ADDR_W-1:0] w_rx;
    logic [REG_ADDR_W-1:0] w_ry;
    logic [ALU_SEL_W-1:0]  w_alu;
    logic [1:0]            w_fmt;
    logic [IMM_W-1:0]      w_imm;
    fmt_class_t            w_cls;
    logic                  w_wr_en;
    logic [NUM_REGS-1:0]   w_reg_en;

    // Field decode of the latched instruction (Ry and imm overlap by design)
    assign w_rx  = r_ir[INSTR_W-1 -: REG_ADDR_W];
    assign w_ry  = r_ir[INSTR_W-REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_imm = r_ir[INSTR_W-REG_ADDR_W-1 : ALU_SEL_W+2];
    assign w_alu = r_ir[ALU_SEL_W+1:2];
    assign w_fmt = r_ir[1:0];
    assign w_cls = classify_fmt(w_fmt, IMM_EN);

    // Next-state sequencing; run only matters in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.run) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and instruction register; ir loads on the accepting edge only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && bus.run) begin
                r_ir <= bus.instruction;
            end
        end
    end

    // Write-back enable; gating with rst keeps an aborted op from pulsing reg_en
    assign w_wr_en = (r_state == ST_WB) && w_cls.wb && !rst;

    bitty_onehot_dec #(
        .W (REG_ADDR_W)
    ) u_dec (
        .i_idx    (w_rx),
        .i_en     (w_wr_en),
        .o_onehot (w_reg_en)
    );

    assign bus.reg_en    = w_reg_en;
    assign bus.imm_value = w_imm;

    // Per-state datapath controls; everything is 0 outside its own state and during reset
    always_comb begin
        bus.alu_sel = '0;
        bus.mux_sel = '0;
        bus.imm_sel = 1'b0;
        bus.en_i    = 1'b0;
        bus.en_s    = 1'b0;
        bus.en_c    = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.illegal = 1'b0;
        if (!rst) begin
            bus.busy = (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    bus.en_i = bus.run;
                end
                ST_LOAD: begin
                    bus.en_s    = 1'b1;
                    bus.mux_sel = w_rx;
                end
                ST_EXEC: begin
                    bus.en_c    = 1'b1;
                    bus.alu_sel = w_alu;
                    if (w_cls.imm) begin
                        bus.imm_sel = 1'b1;
                        bus.mux_sel = '0;
                    end else begin
                        bus.mux_sel = w_ry;
                    end
                end
                ST_DONE: begin
                    bus.done    = 1'b1;
                    bus.illegal = w_cls.ill;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_ctrl_fsm.sv
// Self-checking bench for bitty_ctrl_fsm (default 16/3/3 configuration).
// Honours BITTY_IMM_EN the same way the design does.
module tb_bitty_ctrl_fsm;

    localparam int INSTR_W    = 16;
    localparam int REG_ADDR_W = 3;
    localparam int ALU_SEL_W  = 3;

`ifdef BITTY_IMM_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] alu_sel;
        logic [2:0] mux_sel;
        logic       imm_sel;
        logic [7:0] imm_value;
        logic [7:0] reg_en;
        logic       en_i;
        logic       en_s;
        logic       en_c;
        logic       busy;
        logic       done;
        logic       illegal;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitty_ctrl_if #(.INSTR_W(INSTR_W), .REG_ADDR_W(REG_ADDR_W), .ALU_SEL_W(ALU_SEL_W)) bus ();

    bitty_ctrl_fsm #(.INSTR_W(INSTR_W), .REG_ADDR_W(REG_ADDR_W), .ALU_SEL_W(ALU_SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: cycles remaining in the current instruction and the latched word
    int          m_left = 0;
    logic [15:0] m_ir   = '0;

    function automatic logic [15:0] mk(input int rx, input int ry, input int mid, input int alu, input int fmt);
        return 16'((rx % 8) * 8192 + (ry % 8) * 1024 + (mid % 32) * 32 + (alu % 8) * 4 + (fmt % 4));
    endfunction

    function automatic logic [15:0] mk_imm(input int rx, input int imm, input int alu, input int fmt);
        return 16'((rx % 8) * 8192 + (imm % 256) * 32 + (alu % 8) * 4 + (fmt % 4));
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.alu_sel   = bus.alu_sel;
        o.mux_sel   = bus.mux_sel;
        o.imm_sel   = bus.imm_sel;
        o.imm_value = bus.imm_value;
        o.reg_en    = bus.reg_en;
        o.en_i      = bus.en_i;
        o.en_s      = bus.en_s;
        o.en_c      = bus.en_c;
        o.busy      = bus.busy;
        o.done      = bus.done;
        o.illegal   = bus.illegal;
        return o;
    endfunction

    // Expected outputs from the instruction's progress through its 5-cycle schedule
    function automatic outs_t model_expect(input logic run_in, input logic rst_in);
        outs_t e;
        int  w, rx, ry, alu, fmt;
        bit  is_imm, writes, bad;
        e = '0;
        if (rst_in) return e;
        w      = int'(m_ir);
        rx     = w / 8192;
        ry     = (w / 1024) % 8;
        alu    = (w / 4) % 8;
        fmt    = w % 4;
        is_imm = IMM_EN && (fmt == 1);
        writes = (fmt == 0) || is_imm;
        bad    = (fmt == 3) || ((fmt == 1) && !IMM_EN);
        e.imm_value = 8'((w / 32) % 256);
        e.busy      = (m_left != 0);
        case (m_left)
            0: e.en_i = run_in;
            4: begin e.en_s = 1'b1; e.mux_sel = 3'(rx); end
            3: begin
                e.en_c    = 1'b1;
                e.alu_sel = 3'(alu);
                e.imm_sel = is_imm;
                e.mux_sel = is_imm ? 3'd0 : 3'(ry);
            end
            2: e.reg_en = writes ? 8'(1 << rx) : 8'h00;
            1: begin e.done = 1'b1; e.illegal = bad; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock: drive inputs, sample at negedge, advance model at posedge
    task automatic step(input logic run_in, input logic [15:0] instr_in, input logic rst_in,
                        output outs_t obs, output outs_t exp);
        bus.run         = run_in;
        bus.instruction = instr_in;
        rst             = rst_in;
        @(negedge clk);
        obs = observe();
        exp = model_expect(run_in, rst_in);
        @(posedge clk);
        if (rst_in) begin
            m_left = 0;
            m_ir   = '0;
        end else if (m_left == 0 && run_in) begin
            m_left = 4;
            m_ir   = instr_in;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end
        #1;
        cyc++;
    endtask

    // Single instruction: run for one cycle, then five cycles with junk on instruction
    task automatic run_one(input logic [15:0] instr, output outs_t obs[6], output outs_t exp[6]);
        step(1'b1, instr, 1'b0, obs[0], exp[0]);
        for (int i = 1; i < 6; i++) begin
            step(1'b0, 16'($urandom), 1'b0, obs[i], exp[i]);
        end
    endtask

    task automatic test_reset();
        outs_t o, e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'($urandom), 1'b1, o, e);
            n_checks++;
            if (o !== '0) $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, o);
            else n_pass++;
        end
        step(1'b0, 16'h0000, 1'b0, o, e);
        n_checks++;
        if (o !== e) $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, o, e);
        else n_pass++;
    endtask

    task automatic test_reg_reg();
        outs_t o[6], e[6];
        run_one(mk(2, 5, int'($urandom_range(0, 31)), 3, 0), o, e);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (o[i] !== e[i]) $display("FAIL regreg_model off=%0d got=%h exp=%h", i, o[i], e[i]);
            else n_pass++;
        end
        n_checks++;
        if ({o[0].en_i, o[0].busy} !== 2'b10) $display("FAIL regreg_en_i got=%b exp=10", {o[0].en_i, o[0].busy});
        else n_pass++;
        n_checks++;
        if ({o[1].en_s, o[1].mux_sel} !== {1'b1, 3'd2}) $display("FAIL regreg_load got=%h exp=a", {o[1].en_s, o[1].mux_sel});
        else n_pass++;
        n_checks++;
        if ({o[2].en_c, o[2].alu_sel, o[2].mux_sel} !== {1'b1, 3'd3, 3'd5}) $display("FAIL regreg_exec got=%h exp=5d", {o[2].en_c, o[2].alu_sel, o[2].mux_sel});
        else n_pass++;
        n_checks++;
        if (o[3].reg_en !== 8'h04) $display("FAIL regreg_wb got=%h exp=04", o[3].reg_en);
        else n_pass++;
        n_checks++;
        if ({o[4].done, o[4].illegal, o[5].done, o[5].busy} !== 4'b1000) $display("FAIL regreg_done got=%b exp=1000", {o[4].done, o[4].illegal, o[5].done, o[5].busy});
        else n_pass++;
    endtask

    task automatic test_test_fmt();
        outs_t o[6], e[6];
        run_one(mk(7, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), 6, 2), o, e);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (o[i] !== e[i]) $display("FAIL testfmt_model off=%0d got=%h exp=%h", i, o[i], e[i]);
            else n_pass++;
        end
        n_checks++;
        if ({o[3].reg_en, o[3].busy, o[4].done, o[4].illegal} !== {8'h00, 3'b110}) $display("FAIL testfmt_nowrite got=%h exp=006", {o[3].reg_en, o[3].busy, o[4].done, o[4].illegal});
        else n_pass++;
    endtask

    task automatic test_illegal();
        outs_t o[6], e[6];
        logic [7:0] any_en;
        run_one(mk(int'($urandom_range(0, 7)), 1, 7, 5, 3), o, e);
        any_en = '0;
        for (int i = 0; i < 6; i++) begin
            any_en |= o[i].reg_en;
            n_checks++;
            if (o[i] !== e[i]) $display("FAIL illegal_model off=%0d got=%h exp=%h", i, o[i], e[i]);
            else n_pass++;
        end
        n_checks++;
        if (any_en !== 8'h00) $display("FAIL illegal_nowrite got=%h exp=00", any_en);
        else n_pass++;
        n_checks++;
        if ({o[4].done, o[4].illegal, o[5].done, o[5].illegal, o[3].illegal} !== 5'b11000) $display("FAIL illegal_pulse got=%b exp=11000", {o[4].done, o[4].illegal, o[5].done, o[5].illegal, o[3].illegal});
        else n_pass++;
    endtask

    task automatic test_imm();
        outs_t o[6], e[6];
        int rx;
        rx = int'($urandom_range(0, 7));
        run_one(mk_imm(rx, 8'hA5, 4, 1), o, e);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (o[i] !== e[i]) $display("FAIL imm_model off=%0d got=%h exp=%h", i, o[i], e[i]);
            else n_pass++;
        end
        n_checks++;
        if (o[2].imm_value !== 8'hA5) $display("FAIL imm_value got=%h exp=a5", o[2].imm_value);
        else n_pass++;
`ifdef BITTY_IMM_EN
        n_checks++;
        if ({o[2].imm_sel, o[2].mux_sel, o[3].reg_en, o[4].illegal} !== {1'b1, 3'd0, 8'(1 << rx), 1'b0})
            $display("FAIL imm_exec got=%h exp=%h", {o[2].imm_sel, o[2].mux_sel, o[3].reg_en, o[4].illegal}, {1'b1, 3'd0, 8'(1 << rx), 1'b0});
        else n_pass++;
`else
        n_checks++;
        if ({o[2].imm_sel, o[3].reg_en, o[4].done, o[4].illegal} !== {1'b0, 8'h00, 2'b11})
            $display("FAIL imm_disabled got=%h exp=003", {o[2].imm_sel, o[3].reg_en, o[4].done, o[4].illegal});
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_exec();
        outs_t o, e;
        logic [7:0] any_en;
        step(1'b1, mk(4, 1, 0, 2, 0), 1'b0, o, e);
        step(1'b0, 16'h0000, 1'b0, o, e);
        step(1'b0, 16'h0000, 1'b1, o, e);
        n_checks++;
        if (o !== '0) $display("FAIL rstexec_async got=%h exp=0", o);
        else n_pass++;
        any_en = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'($urandom), 1'b0, o, e);
            any_en |= o.reg_en;
            if (i == 0) begin
                n_checks++;
                if ({o.busy, o.en_i, o.en_s, o.en_c, o.done} !== 5'b0) $display("FAIL rstexec_idle got=%b exp=00000", {o.busy, o.en_i, o.en_s, o.en_c, o.done});
                else n_pass++;
            end
        end
        n_checks++;
        if (any_en !== 8'h00) $display("FAIL rstexec_nowrite got=%h exp=00", any_en);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        outs_t o, e;
        logic [15:0] instrs[12];
        int done_at[$];
        int wr_at[$];
        int wr_idx[$];
        int acc[$];
        for (int i = 0; i < 12; i++) instrs[i] = mk(int'($urandom_range(0, 7)), int'($urandom), int'($urandom), int'($urandom), 0);
        for (int i = 0; i < 12; i += 5) acc.push_back(i);
        for (int i = 0; i < 18; i++) begin
            step(i < 12, (i < 12) ? instrs[i] : 16'($urandom), 1'b0, o, e);
            n_checks++;
            if (o !== e) $display("FAIL b2b_model off=%0d got=%h exp=%h", i, o, e);
            else n_pass++;
            if (o.done === 1'b1) done_at.push_back(i);
            for (int b = 0; b < 8; b++) if (o.reg_en[b] === 1'b1) begin wr_at.push_back(i); wr_idx.push_back(b); end
        end
        n_checks++;
        if (done_at.size() != 3 || wr_at.size() != 3) $display("FAIL b2b_count got=%0d/%0d exp=3/3", done_at.size(), wr_at.size());
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            if (k < done_at.size() && k < wr_at.size()) begin
                n_checks++;
                if (done_at[k] != acc[k] + 4 || wr_at[k] != acc[k] + 3 || wr_idx[k] != int'(instrs[acc[k]]) / 8192)
                    $display("FAIL b2b_op%0d got=done%0d/wr%0d/r%0d exp=done%0d/wr%0d/r%0d", k, done_at[k], wr_at[k], wr_idx[k],
                             acc[k] + 4, acc[k] + 3, int'(instrs[acc[k]]) / 8192);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        outs_t o, e;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 49) == 0), o, e);
            n_checks++;
            if (o !== e || $countones(o.reg_en) > 1) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
            else n_pass++;
        end
    endtask

    initial begin
        bus.run         = 1'b0;
        bus.instruction = '0;
        test_reset();
        test_reg_reg();
        test_test_fmt();
        test_illegal();
        test_imm();
        test_reset_mid_exec();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
